// File: rtl/lfsr_sequencer.sv
// 8-bit maximal-length Fibonacci LFSR pattern generator with prescaled stepping,
// burst counting and a valid/ready output handshake.
module lfsr_sequencer #(
    parameter int PRESCALE_WIDTH = 22,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   LOAD,
    input  logic [7:0]             SEED,
    input  logic                   START,
    input  logic [COUNT_WIDTH-1:0] COUNT,
    input  logic                   STOP,
    input  logic                   READY,
    output logic [7:0]             O,
    output logic                   VALID,
    output logic                   BUSY,
    output logic                   DONE
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_PRESENT  = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]    REM_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]    REM_ZERO  = COUNT_WIDTH'(0);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ZERO  = PRESCALE_WIDTH'(0);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE   = PRESCALE_WIDTH'(1);

    // Polynomial x^8+x^6+x^5+x^4+1; the all-zero state is never entered.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] seed_fix(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    state_t                  state_r, state_next_s;
    logic [7:0]              word_r, word_next_s;
    logic                    valid_r, valid_next_s;
    logic                    busy_r;
    logic                    done_r, done_next_s;
    logic [PRESCALE_WIDTH-1:0] presc_r, presc_next_s, presc_inc_s;
    logic [COUNT_WIDTH-1:0]  remaining_r, remaining_next_s;
    logic                    tick_s;
    logic                    abort_s;

    assign presc_inc_s = presc_r + PRE_ONE;
    assign tick_s      = &presc_r;
    assign abort_s     = LOAD || (STOP && (state_r != ST_IDLE));

    // Next-state, datapath and handshake decisions; abort paths take priority.
    always_comb begin
        state_next_s     = state_r;
        word_next_s      = word_r;
        valid_next_s     = valid_r;
        done_next_s      = 1'b0;
        presc_next_s     = presc_r;
        remaining_next_s = remaining_r;

        if (abort_s) begin
            state_next_s = ST_IDLE;
            valid_next_s = 1'b0;
            if (LOAD) begin
                word_next_s = seed_fix(SEED);
            end else begin
                word_next_s = word_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_next_s = 1'b0;
                    if (START) begin
                        state_next_s     = ST_COUNTING;
                        remaining_next_s = COUNT;
                        presc_next_s     = PRE_ZERO;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_COUNTING: begin
                    presc_next_s = presc_inc_s;
                    if (tick_s) begin
                        word_next_s  = lfsr_step(word_r);
                        valid_next_s = 1'b1;
                        state_next_s = ST_PRESENT;
                    end else begin
                        valid_next_s = 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (valid_r && READY) begin
                        presc_next_s = presc_inc_s;
                        if (remaining_r == REM_ONE) begin
                            // Last word of a counted burst: finish without stepping.
                            state_next_s = ST_IDLE;
                            valid_next_s = 1'b0;
                            done_next_s  = 1'b1;
                        end else begin
                            if (remaining_r != REM_ZERO) begin
                                remaining_next_s = remaining_r - REM_ONE;
                            end else begin
                                remaining_next_s = remaining_r;
                            end
                            if (tick_s) begin
                                word_next_s  = lfsr_step(word_r);
                                valid_next_s = 1'b1;
                            end else begin
                                valid_next_s = 1'b0;
                                state_next_s = ST_COUNTING;
                            end
                        end
                    end else begin
                        presc_next_s = presc_r;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_r     <= ST_IDLE;
            word_r      <= 8'h01;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            presc_r     <= PRE_ZERO;
            remaining_r <= REM_ZERO;
        end else begin
            state_r     <= state_next_s;
            word_r      <= word_next_s;
            valid_r     <= valid_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= done_next_s;
            presc_r     <= presc_next_s;
            remaining_r <= remaining_next_s;
        end
    end

    assign O     = word_r;
    assign VALID = valid_r;
    assign BUSY  = busy_r;
    assign DONE  = done_r;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Scoreboard bench for lfsr_sequencer: expected words are queued at stimulus
// time and compared as the DUT hands each word over.
module tb_lfsr_sequencer;

    localparam int PW = 2;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic          LOAD = 1'b0;
    logic [7:0]    SEED = 8'h00;
    logic          START = 1'b0;
    logic [CW-1:0] COUNT = '0;
    logic          STOP = 1'b0;
    logic          READY = 1'b0;
    logic [7:0]    O;
    logic          VALID;
    logic          BUSY;
    logic          DONE;

    int err_cnt = 0;
    int chk_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_xfer = -1;
    bit space_en = 1'b0;
    logic [7:0] sb_q[$];

    lfsr_sequencer #(.PRESCALE_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
        .CLK(CLK), .RESETN(RESETN), .LOAD(LOAD), .SEED(SEED), .START(START),
        .COUNT(COUNT), .STOP(STOP), .READY(READY), .O(O), .VALID(VALID),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Monitor: a handshake seen here completes on the following rising edge.
    always @(negedge CLK) begin
        if (VALID && READY) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
            end else begin
                check_val("word", 32'(O), 32'(sb_q.pop_front()));
            end
            if (space_en) begin
                if (last_xfer >= 0) check_val("spacing", 32'(cyc - last_xfer), 32'd4);
                last_xfer = cyc;
            end
        end
        if (DONE) begin
            done_cnt++;
            check_val("busy_at_done", 32'(BUSY), 32'd0);
        end
    end

    task automatic tick1();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [7:0] s);
        LOAD = 1'b1;
        SEED = s;
        tick1();
        LOAD = 1'b0;
    endtask

    task automatic do_start(input logic [CW-1:0] c);
        COUNT = c;
        START = 1'b1;
        tick1();
        START = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!VALID && n < budget) begin
            tick1();
            n++;
        end
        check_val("valid_seen", 32'(VALID), 32'd1);
    endtask

    task automatic wait_sb(input int budget, input bit need_idle);
        int n = 0;
        while ((sb_q.size() != 0 || (need_idle && BUSY)) && n < budget) begin
            tick1();
            n++;
        end
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        logic [7:0] w;

        // Reset state
        tick1();
        RESETN = 1'b1;
        check_val("rst_o", 32'(O), 32'h01);
        check_val("rst_valid", 32'(VALID), 32'd0);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        check_val("rst_done", 32'(DONE), 32'd0);

        // Counted burst of four with latency and spacing
        do_load(8'h01);
        READY = 1'b1;
        sb_q.push_back(8'h02); sb_q.push_back(8'h04);
        sb_q.push_back(8'h08); sb_q.push_back(8'h11);
        space_en = 1'b1;
        last_xfer = -1;
        d0 = done_cnt;
        do_start(8'd4);
        n = 0;
        do begin
            tick1();
            n++;
        end while (!VALID && n < 20);
        check_val("first_latency", 32'(n), 32'd4);
        wait_sb(100, 1'b1);
        tick1(); tick1();
        space_en = 1'b0;
        check_val("burst4_done", 32'(done_cnt - d0), 32'd1);
        check_val("burst4_busy", 32'(BUSY), 32'd0);

        // Zero seed substitution
        do_load(8'h00);
        check_val("seed_zero_o", 32'(O), 32'h01);
        sb_q.push_back(8'h02); sb_q.push_back(8'h04);
        d0 = done_cnt;
        do_start(8'd2);
        wait_sb(60, 1'b1);
        tick1(); tick1();
        check_val("burst2_done", 32'(done_cnt - d0), 32'd1);

        // Backpressure on first word
        do_load(8'h01);
        READY = 1'b0;
        sb_q.push_back(8'h02); sb_q.push_back(8'h04); sb_q.push_back(8'h08);
        d0 = done_cnt;
        do_start(8'd3);
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            tick1();
            check_val("stall_o", 32'(O), 32'h02);
            check_val("stall_valid", 32'(VALID), 32'd1);
        end
        READY = 1'b1;
        n = 0;
        do begin
            tick1();
            n++;
        end while (!(VALID && O == 8'h04) && n < 20);
        check_val("after_stall_latency", 32'(n), 32'd4);
        wait_sb(60, 1'b1);
        tick1(); tick1();
        check_val("burst3_done", 32'(done_cnt - d0), 32'd1);

        // Free-run full period, then STOP while presenting
        do_load(8'h01);
        w = 8'h01;
        for (int i = 0; i < 255; i++) begin
            w = ref_step(w);
            sb_q.push_back(w);
        end
        d0 = done_cnt;
        READY = 1'b1;
        do_start(8'd0);
        wait_sb(1200, 1'b0);
        READY = 1'b0;
        check_val("freerun_o_wrapped", 32'(O), 32'h01);
        wait_valid(20);
        check_val("freerun_next", 32'(O), 32'h02);
        STOP = 1'b1;
        tick1();
        STOP = 1'b0;
        check_val("stop_valid", 32'(VALID), 32'd0);
        check_val("stop_busy", 32'(BUSY), 32'd0);
        check_val("stop_o_kept", 32'(O), 32'h02);
        tick1(); tick1();
        check_val("freerun_no_done", 32'(done_cnt - d0), 32'd0);

        // STOP+LOAD in PRESENT, then START+LOAD in IDLE
        do_load(8'h01);
        do_start(8'd0);
        wait_valid(20);
        STOP = 1'b1;
        LOAD = 1'b1;
        SEED = 8'h47;
        tick1();
        STOP = 1'b0;
        LOAD = 1'b0;
        check_val("stopload_o", 32'(O), 32'h47);
        check_val("stopload_valid", 32'(VALID), 32'd0);
        check_val("stopload_busy", 32'(BUSY), 32'd0);
        START = 1'b1;
        LOAD = 1'b1;
        SEED = 8'h5a;
        tick1();
        START = 1'b0;
        LOAD = 1'b0;
        check_val("startload_o", 32'(O), 32'h5a);
        check_val("startload_busy", 32'(BUSY), 32'd0);
        repeat (6) tick1();
        check_val("startload_idle_valid", 32'(VALID), 32'd0);
        check_val("startload_idle_busy", 32'(BUSY), 32'd0);

        // Reset while presenting
        d0 = done_cnt;
        do_start(8'd5);
        wait_valid(20);
        RESETN = 1'b0;
        tick1();
        RESETN = 1'b1;
        check_val("rst2_o", 32'(O), 32'h01);
        check_val("rst2_valid", 32'(VALID), 32'd0);
        check_val("rst2_busy", 32'(BUSY), 32'd0);
        check_val("rst2_done", 32'(DONE), 32'd0);
        repeat (6) tick1();
        check_val("rst2_stays_idle", 32'(BUSY), 32'd0);
        check_val("rst2_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("sb_left", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
